// File: rtl/addsub_accum_if.sv
// Sample stream in, block-result stream out, plus block control for addsub_accum.
// master drives samples/control and takes results; slave is the accumulator.
interface addsub_accum_if #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 16
);
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             in_ready;
    logic [7:0]       cfg_len;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [8:0]       out_count;
    logic             out_sat;

    modport master (
        output in_valid, in_data, cfg_len, flush, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_sat
    );

    modport slave (
        input  in_valid, in_data, cfg_len, flush, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_sat
    );
endinterface

// File: rtl/addsub_accum.sv
// Saturating signed block accumulator over the add/sub result stream; result registered 1 cycle after the closing beat/flush.
// Backpressure: in_ready drops while a block result waits in HOLD and returns the cycle after the out handshake.
module addsub_accum #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    addsub_accum_if.slave bus
);
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t           state;
    state_t           state_nxt;

    logic [ACC_W-1:0] acc;
    logic [8:0]       count;
    logic [8:0]       len_q;
    logic             sat;

    logic             out_valid_q;
    logic [ACC_W-1:0] out_sum_q;
    logic [8:0]       out_count_q;
    logic             out_sat_q;

    logic             in_ready;
    logic             beat;
    logic             close;
    logic [8:0]       cfg_len_eff;
    logic [8:0]       blk_len;
    logic [8:0]       count_inc;
    logic [ACC_W:0]   sum_wide;
    logic             ovf;
    logic [ACC_W-1:0] sum_sat;
    logic [ACC_W-1:0] acc_post;
    logic [8:0]       count_post;
    logic             sat_post;

    assign beat        = bus.in_valid && in_ready;
    assign cfg_len_eff = (bus.cfg_len == 8'd0) ? 9'd256 : {1'b0, bus.cfg_len};
    // The first beat of a block uses the live cfg_len; later beats use the latched copy.
    assign blk_len     = (count == 9'd0) ? cfg_len_eff : len_q;
    assign count_inc   = count + 9'd1;

    // One guard bit is enough: a single IN_W sample can overshoot the range by less than 2^(ACC_W-1).
    assign sum_wide = {acc[ACC_W-1], acc}
                    + {{(ACC_W+1-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
    assign ovf      = sum_wide[ACC_W] != sum_wide[ACC_W-1];

    always_comb begin
        sum_sat = sum_wide[ACC_W-1:0];
        if (ovf) begin
            sum_sat = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    assign acc_post   = beat ? sum_sat : acc;
    assign count_post = beat ? count_inc : count;
    assign sat_post   = sat | (beat & ovf);

    assign close = (state == ACCUM)
                && ((beat && (count_inc == blk_len))
                    || (bus.flush && ((count != 9'd0) || beat)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: if (close)         state_nxt = HOLD;
            HOLD:  if (bus.out_ready) state_nxt = ACCUM;
        endcase
    end

    always_comb begin
        in_ready = (state == ACCUM) && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc         <= '0;
            count       <= '0;
            len_q       <= '0;
            sat         <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (beat) begin
                        acc   <= sum_sat;
                        count <= count_inc;
                        sat   <= sat_post;
                        if (count == 9'd0) begin
                            len_q <= cfg_len_eff;
                        end
                    end
                    if (close) begin
                        out_valid_q <= 1'b1;
                        out_sum_q   <= acc_post;
                        out_count_q <= count_post;
                        out_sat_q   <= sat_post;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        acc         <= '0;
                        count       <= '0;
                        sat         <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_sat   = out_sat_q;

`ifndef SYNTHESIS
    out_hold_stable: assert property (@(posedge clk) disable iff (reset)
        (out_valid_q && !bus.out_ready) |=>
            (out_valid_q && $stable(out_sum_q) && $stable(out_count_q) && $stable(out_sat_q)));
`endif
endmodule

// File: doc/addsub_accum.md
# addsub_accum

Downstream stage of the registered 8-bit add/subtract unit: consumes its per-cycle `result` stream, sign-extended, and accumulates it into a saturating signed running sum over a block of programmable length. At block end it presents the sum, beat count and saturation flag on a valid/ready output port. It holds off upstream while the result is waiting. Typical consumer: statistics/readout logic or a bus register slice.

## Interface
- `IN_W`, default 8: input sample width; two's-complement signed.
- `ACC_W`, default 16: accumulator width, signed; must satisfy ACC_W > IN_W.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: `in_data` holds a sample this cycle.
- `in_data`, input, IN_W: sample; normally the add/sub unit `result`.
- `in_ready`, output, 1: stage accepts a sample this cycle. A beat transfers when `in_valid && in_ready`.
- `cfg_len`, input, 8: block length in beats; 0 means 256. Sampled on the first beat of each block.
- `flush`, input, 1: close the current block early.
- `out_valid`, output, 1: block result available.
- `out_ready`, input, 1: consumer takes the result.
- `out_sum`, output, ACC_W: saturated signed block sum.
- `out_count`, output, 9: beats in the block, 1..256.
- `out_sat`, output, 1: saturation occurred at least once in the block.

## Operation
- Two-state FSM: ACCUM and HOLD.
- **ACCUM state**
  - `in_ready` = 1.
  - On each accepted beat: `acc <= sat(acc + sext(in_data))`, and `count <= count + 1`.
  - On the first beat of a block (count == 0), latch `len` from `cfg_len` (0 maps to 256).
- **Block close**
  - Condition: an accepted beat makes count+1 == len, OR `flush` is high while (count > 0 or a beat is accepted).
  - On close: load `out_sum`/`out_count`/`out_sat` with the post-beat values and go to HOLD.
  - `flush` with count == 0 and no beat is ignored.
  - `flush` together with a beat: the beat is included, then the block closes.
- **Saturation**
  - Compute the sum at ACC_W+1 bits.
  - Above 2^(ACC_W-1)-1: clamp to max. Below -2^(ACC_W-1): clamp to min.
  - Either clamp sets the sticky `sat` bit, which clears at block start.
  - Accumulation continues from the clamped value.
- **HOLD state**
  - `in_ready` = 0, `out_valid` = 1, outputs held stable.
  - On `out_ready`: clear acc, count and sat, then return to ACCUM.
  - `flush`, `cfg_len` and `in_data` are ignored in HOLD.
- **Reset**
  - State goes to ACCUM; acc, count, sat, `out_sum`, `out_count`, `out_sat` and `out_valid` all go to 0.
  - `in_ready` = 0 while `reset` is high, and 1 on the first cycle after release.
  - Reset mid-block or in HOLD discards the partial block or pending result; no output is produced for it.

## Timing
- `in_ready` is combinational: (state == ACCUM) && !reset.
- `out_valid`, `out_sum`, `out_count` and `out_sat` are registered.
- `out_valid` rises on the cycle after the closing beat or flush is accepted.
- `out_valid` falls on the cycle after the `out_valid && out_ready` handshake.
- The first beat of the next block can be accepted on that same following cycle. Minimum period is len+1 cycles per block.
- `out_valid` never drops without a handshake. Outputs do not change while `out_valid && !out_ready`.
- No combinational path from `out_ready` to `in_ready` other than through the state register.

## Test plan
- **Basic sum:** `cfg_len`=4; beats 10, 20, 0xFB, 3 back-to-back, `out_ready`=1.
  - Expect `out_valid` one cycle after beat 4, with `out_sum`=0x001C, `out_count`=4, `out_sat`=0.
  - Expect `in_ready` low for exactly one cycle.
- **Saturation, ACC_W=10:**
  - Five beats of 0x7F with `cfg_len`=5 -> `out_sum`=0x1FF, `out_sat`=1.
  - Five beats of 0x80 -> `out_sum`=0x200, `out_sat`=1.
- **Backpressure:** `cfg_len`=2, beats 1 and 2, `out_ready` held 0 for 3 cycles while `in_valid`=1 with data 7.
  - `out_sum`=3 stays stable and `in_ready`=0 throughout.
  - After the handshake the next block starts with 7; no beat is lost or duplicated.
- **Flush:** `cfg_len`=8; beats 1, 2, 3, then beat 4 with `flush`=1.
  - Expect `out_sum`=10, `out_count`=4.
  - An idle cycle with `flush`=1 and count 0 must produce no output.
- **Length 0:** `cfg_len`=0 with 256 beats of 1 -> `out_count`=256, `out_sum`=256.
  - Changing `cfg_len` mid-block has no effect on the current block.
- **Reset mid-operation:**
  - Pulse `reset` after 2 beats of a `cfg_len`=4 block: no `out_valid`, and the next 4 beats of 5 give `out_sum`=20.
  - Pulse `reset` during HOLD: `out_valid` clears on the next edge and all outputs read 0.
